data_mem_lsu: RTL and testbench
===============================

// Module: data_mem_lsu
// PURPOSE
// - Parametrised data memory plus load/store unit for the RISC-V datapath.
// - Successor to the word-only data memory: adds RV32I byte/half/word loads (signed/unsigned), byte-lane
//   stores, a registered read port with a valid/ready response, a memory-mapped GPIO, and error detection.
// - Sits between the EX stage (address from ALU) and the WB mux.
// PARAMETERS
// - DEPTH_WORDS  256           number of 32-bit words; byte range 0 .. 4*DEPTH_WORDS-1
// - GPIO_ADDR    32'h0000ABCD  full-address match for GPIO register (word access only, alignment exempt)
// - GPIO_W       16            width of gpio_out / gpio_in
// - ERRCNT_W     8             width of saturating error counter
// PORTS
// - clock      in   1         single clock, all state on rising edge
// - reset      in   1         synchronous, active-high
// - req_valid  in   1         request present this cycle
// - req_ready  out  1         1 = request accepted on this edge
// - req_we     in   1         1 = store, 0 = load
// - req_funct3 in   3         RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - req_addr   in   32        byte address
// - req_wdata  in   32        store data (LSBs used for B/H)
// - rsp_valid  out  1         one-cycle pulse, response to request accepted previous edge
// - rsp_rdata  out  32        load result, extended per funct3; 0 for stores and errors
// - rsp_err    out  1         request faulted (misaligned, out of range, illegal funct3, sub-word GPIO)
// - gpio_out   out  GPIO_W    GPIO output register
// - gpio_in    in   GPIO_W    asynchronous GPIO inputs
// - err_count  out  ERRCNT_W  saturating count of faulted requests
// BEHAVIOUR
// - Reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, gpio_out=0, err_count=0, gpio_in sync flops=0. Memory contents
//   are NOT cleared. A request in flight when reset asserts is dropped; no rsp_valid follows.
// - req_ready = !reset. Throughput one request/cycle; every accepted request yields exactly one rsp_valid
//   pulse on the next cycle (latency 1).
// - Illegal funct3 (011, 110, 111; loads and stores alike) -> err. For stores, funct3 100/101 are illegal.
// - Fault check (first match wins): illegal funct3; addr == GPIO_ADDR with funct3 != 010; addr != GPIO_ADDR and
//   (H with addr[0]!=0 or W with addr[1:0]!=0); addr != GPIO_ADDR and addr >= 4*DEPTH_WORDS.
// - Faulted request: no memory/GPIO write; rsp_err=1, rsp_rdata=0; err_count += 1, holding at all-ones.
// - Store: word index addr[log2(4*DEPTH_WORDS)-1:2]; byte enables SB=1<<addr[1:0], SH=3<<{addr[1],1'b0}, SW=4'hF;
//   wdata replicated to lanes. Committed on accepting edge.
// - Load: synchronous read; lane selected by registered addr[1:0]; B/H sign-extend, BU/HU zero-extend.
// - Load immediately after store to same word, next cycle, returns the new data (write committed first).
// - GPIO: SW at GPIO_ADDR loads gpio_out <= wdata[GPIO_W-1:0]; LW returns zero-extended 2-flop-synchronised
//   gpio_in. GPIO never aliases memory.
// STRUCTURE
// - Shared package: funct3 localparams (F3_B/H/W/BU/HU), RESP_OK/ERR encoding, default GPIO_ADDR.
// - One sub-module: dmem_bram_be (single-port, 4-lane byte-enable RAM, 1-cycle registered read, no reset on
//   array). Top holds decode, fault check, extension mux, GPIO and counter.
// TESTING
// - SW 1114 @36, then LW @36 -> rsp_valid next cycle, rdata=1114, err=0; LW @12 after init -> preloaded word 3.
// - SW 0 @12; SB 0x80 @13; LB @13 -> 0xFFFFFF80; LBU @13 -> 0x00000080; LW @12 -> 0x00008000.
// - LW @14, SH @37, funct3=011 -> each err=1, rdata=0; memory unchanged; err_count=3.
// - LW @4*DEPTH_WORDS -> err; 300 consecutive faults -> err_count saturates at 255.
// - SW 0xBEEF @GPIO_ADDR -> gpio_out=0xBEEF; gpio_in=0x1234 then LW @GPIO_ADDR (after 2-flop sync)
//   -> 0x00001234; SB @GPIO_ADDR -> err, gpio_out unchanged.
// - Back-to-back SW 0xA5A5A5A5 @40 then LW @40 -> 0xA5A5A5A5; assert reset in the cycle after a load
//   -> no rsp_valid, gpio_out=0, err_count=0, mem @40 still 0xA5A5A5A5.

Source files
------------

// File: rtl/data_mem_lsu_pkg.sv
// Shared constants for the data memory / load-store unit: funct3 codes,
// response encoding and the default GPIO register address.
package data_mem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  localparam logic [31:0] GPIO_ADDR_DEFAULT = 32'h0000_ABCD;

  // Stores only take B/H/W; loads additionally take BU/HU.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
         (!we && ((f3 == F3_BU) || (f3 == F3_HU)));
    return !ok;
  endfunction

endpackage

// File: rtl/dmem_bram_be.sv
// Single-port 4-lane byte-enable RAM with a registered read port.
// The array itself is never reset so it maps onto block RAM.
module dmem_bram_be #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int l = 0; l < 4; l++) begin
        if (be_i[l]) mem_q[addr_i][8*l +: 8] <= wdata_i[8*l +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_lsu.sv
// Data memory plus RV32I load/store unit: decode, fault check, byte-lane
// stores, sign/zero-extended loads, memory-mapped GPIO and a fault counter.
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] GPIO_ADDR   = GPIO_ADDR_DEFAULT,
  parameter int unsigned GPIO_W      = 16,
  parameter int unsigned ERRCNT_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic [GPIO_W-1:0]   gpio_out,
  input  logic [GPIO_W-1:0]   gpio_in,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int unsigned BYTE_AW = $clog2(4 * DEPTH_WORDS);
  localparam int unsigned WORD_AW = BYTE_AW - 2;

  logic accept_c, is_gpio_c, fault_c, is_half_c, mem_en_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_rep_c, ram_rdata, rdata_c;

  logic                rsp_valid_q, rsp_err_q, rsp_load_q, rsp_gpio_rd_q;
  logic [2:0]          rsp_f3_q;
  logic [1:0]          rsp_lane_q;
  logic [31:0]         gpio_rd_q;
  logic [GPIO_W-1:0]   gpio_out_q, gpio_s1_q, gpio_s2_q;
  logic [ERRCNT_W-1:0] err_q;

  assign req_ready = !reset;
  assign accept_c  = req_valid && !reset;
  assign is_gpio_c = (req_addr == GPIO_ADDR);
  assign is_half_c = (req_funct3 == F3_H) || (req_funct3 == F3_HU);

  // Fault priority only matters for documentation; any hit faults the request.
  always_comb begin
    fault_c = 1'b0;
    if (f3_illegal(req_we, req_funct3))                    fault_c = 1'b1;
    else if (is_gpio_c && (req_funct3 != F3_W))            fault_c = 1'b1;
    else if (!is_gpio_c && is_half_c && req_addr[0])       fault_c = 1'b1;
    else if (!is_gpio_c && (req_funct3 == F3_W) && (req_addr[1:0] != 2'b00))
                                                           fault_c = 1'b1;
    else if (!is_gpio_c && (req_addr >= 32'(4 * DEPTH_WORDS)))
                                                           fault_c = 1'b1;
  end

  always_comb begin
    be_c        = 4'h0;
    wdata_rep_c = req_wdata;
    case (req_funct3)
      F3_B: begin
        be_c        = 4'b0001 << req_addr[1:0];
        wdata_rep_c = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        be_c        = 4'b0011 << {req_addr[1], 1'b0};
        wdata_rep_c = {2{req_wdata[15:0]}};
      end
      F3_W:    be_c = 4'hF;
      default: be_c = 4'h0;
    endcase
    if (!req_we) be_c = 4'h0;
  end

  assign mem_en_c = accept_c && !fault_c && !is_gpio_c;

  dmem_bram_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (WORD_AW)
  ) u_ram (
    .clk     (clock),
    .en_i    (mem_en_c),
    .be_i    (be_c),
    .addr_i  (req_addr[BYTE_AW-1:2]),
    .wdata_i (wdata_rep_c),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= RESP_OK;
      rsp_load_q    <= 1'b0;
      rsp_gpio_rd_q <= 1'b0;
      rsp_f3_q      <= 3'b000;
      rsp_lane_q    <= 2'b00;
      gpio_rd_q     <= 32'h0;
      gpio_out_q    <= '0;
      gpio_s1_q     <= '0;
      gpio_s2_q     <= '0;
      err_q         <= '0;
    end else begin
      gpio_s1_q     <= gpio_in;
      gpio_s2_q     <= gpio_s1_q;
      rsp_valid_q   <= accept_c;
      rsp_err_q     <= accept_c && fault_c ? RESP_ERR : RESP_OK;
      rsp_load_q    <= mem_en_c && !req_we;
      rsp_gpio_rd_q <= accept_c && !fault_c && is_gpio_c && !req_we;
      rsp_f3_q      <= req_funct3;
      rsp_lane_q    <= req_addr[1:0];
      if (accept_c) gpio_rd_q <= 32'(gpio_s2_q);
      if (accept_c && !fault_c && is_gpio_c && req_we) gpio_out_q <= req_wdata[GPIO_W-1:0];
      if (accept_c && fault_c && (err_q != {ERRCNT_W{1'b1}})) err_q <= err_q + ERRCNT_W'(1);
    end
  end

  // Lane select and extension on the registered RAM output.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    rdata_c = 32'h0;
    b       = 8'h0;
    h       = rsp_lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (rsp_lane_q)
      2'd0:    b = ram_rdata[7:0];
      2'd1:    b = ram_rdata[15:8];
      2'd2:    b = ram_rdata[23:16];
      default: b = ram_rdata[31:24];
    endcase
    if (rsp_gpio_rd_q) begin
      rdata_c = gpio_rd_q;
    end else if (rsp_load_q) begin
      case (rsp_f3_q)
        F3_B:    rdata_c = {{24{b[7]}}, b};
        F3_BU:   rdata_c = {24'h0, b};
        F3_H:    rdata_c = {{16{h[15]}}, h};
        F3_HU:   rdata_c = {16'h0, h};
        default: rdata_c = ram_rdata;
      endcase
    end
  end

  // A response still pending when reset rises is dropped.
  assign rsp_valid = rsp_valid_q && !reset;
  assign rsp_err   = rsp_err_q && !reset;
  assign rsp_rdata = reset ? 32'h0 : rdata_c;
  assign gpio_out  = gpio_out_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu with hand-computed expected values.
module tb_data_mem_lsu;

  localparam logic [31:0] GPIO_A = 32'h0000_ABCD;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] gpio_out, gpio_in;
  logic [7:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_lsu dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .gpio_out   (gpio_out),
    .gpio_in    (gpio_in),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request, let it be accepted, then sit #1 after the edge.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rsp(input string tag, input logic [31:0] rd, input logic er);
    check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".rdata"}, rsp_rdata, rd);
    check({tag, ".err"},   32'(rsp_err), 32'(er));
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0; req_wdata = 32'h0; gpio_in = 16'h0;
    idle(3);
    check("rst.valid", 32'(rsp_valid), 32'd0);
    check("rst.rdata", rsp_rdata, 32'h0);
    check("rst.err",   32'(rsp_err), 32'd0);
    check("rst.gpio",  32'(gpio_out), 32'h0);
    check("rst.errcnt", 32'(err_count), 32'd0);
    check("rst.ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("ready", 32'(req_ready), 32'd1);

    // Preload word 3 then read it back
    issue(1'b1, 3'b010, 32'd12, 32'h3333_0003); rsp("pre.sw", 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'd12, 32'h0);         rsp("pre.lw", 32'h3333_0003, 1'b0);
    issue(1'b1, 3'b010, 32'd36, 32'd1114);      rsp("sw36", 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'd36, 32'h0);         rsp("lw36", 32'd1114, 1'b0);
    idle(1);
    check("pulse", 32'(rsp_valid), 32'd0);

    // Byte store into a cleared word, signed/unsigned reads
    issue(1'b1, 3'b010, 32'd12, 32'h0);         rsp("sw12", 32'h0, 1'b0);
    issue(1'b1, 3'b000, 32'd13, 32'h0000_0080); rsp("sb13", 32'h0, 1'b0);
    issue(1'b0, 3'b000, 32'd13, 32'h0);         rsp("lb13", 32'hFFFF_FF80, 1'b0);
    issue(1'b0, 3'b100, 32'd13, 32'h0);         rsp("lbu13", 32'h0000_0080, 1'b0);
    issue(1'b0, 3'b010, 32'd12, 32'h0);         rsp("lw12", 32'h0000_8000, 1'b0);
    issue(1'b0, 3'b001, 32'd12, 32'h0);         rsp("lh12", 32'hFFFF_8000, 1'b0);
    issue(1'b0, 3'b101, 32'd12, 32'h0);         rsp("lhu12", 32'h0000_8000, 1'b0);
    issue(1'b1, 3'b001, 32'd38, 32'h1234_CAFE); rsp("sh38", 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'd36, 32'h0);         rsp("lw36b", 32'hCAFE_045A, 1'b0);

    // Faults
    issue(1'b0, 3'b010, 32'd14, 32'h0);         rsp("lw14", 32'h0, 1'b1);
    issue(1'b1, 3'b001, 32'd37, 32'hFFFF_FFFF); rsp("sh37", 32'h0, 1'b1);
    issue(1'b0, 3'b011, 32'd36, 32'h0);         rsp("f3_011", 32'h0, 1'b1);
    check("errcnt3", 32'(err_count), 32'd3);
    issue(1'b0, 3'b010, 32'd36, 32'h0);         rsp("unchg36", 32'hCAFE_045A, 1'b1 & 1'b0);
    issue(1'b0, 3'b010, 32'd1024, 32'h0);       rsp("oor", 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'd1020, 32'h0);       check("top.err", 32'(rsp_err), 32'd0);
    issue(1'b1, 3'b100, 32'd40, 32'h0);         rsp("st_bu", 32'h0, 1'b1);
    check("errcnt5", 32'(err_count), 32'd5);
    for (int i = 0; i < 300; i++) issue(1'b0, 3'b010, 32'd14, 32'h0);
    check("errsat", 32'(err_count), 32'd255);
    issue(1'b0, 3'b110, 32'd0, 32'h0);
    check("errhold", 32'(err_count), 32'd255);

    // GPIO
    issue(1'b1, 3'b010, GPIO_A, 32'h5555_BEEF); rsp("gpio.sw", 32'h0, 1'b0);
    check("gpio.out", 32'(gpio_out), 32'h0000_BEEF);
    gpio_in = 16'h1234;
    idle(3);
    issue(1'b0, 3'b010, GPIO_A, 32'h0);         rsp("gpio.lw", 32'h0000_1234, 1'b0);
    issue(1'b1, 3'b000, GPIO_A, 32'h0000_0011); rsp("gpio.sb", 32'h0, 1'b1);
    check("gpio.keep", 32'(gpio_out), 32'h0000_BEEF);

    // Back-to-back store/load, then reset with a load in flight
    issue(1'b1, 3'b010, 32'd40, 32'hA5A5_A5A5); rsp("sw40", 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'd40, 32'h0);         rsp("lw40", 32'hA5A5_A5A5, 1'b0);
    issue(1'b0, 3'b010, 32'd40, 32'h0);
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    check("drop.valid", 32'(rsp_valid), 32'd0);
    @(posedge clock);
    #1;
    check("rst2.valid", 32'(rsp_valid), 32'd0);
    check("rst2.gpio", 32'(gpio_out), 32'h0);
    check("rst2.errcnt", 32'(err_count), 32'd0);
    reset = 1'b0;
    idle(1);
    check("post.valid", 32'(rsp_valid), 32'd0);
    issue(1'b0, 3'b010, 32'd40, 32'h0);         rsp("keep40", 32'hA5A5_A5A5, 1'b0);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
